// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the dmem_responder slice.
//   state_t      - responder FSM states
//   dmem_req_t   - captured request (we, funct3, addr, wdata)
//   F3_*         - RV32I load/store funct3 encodings
//   req_err()    - illegal-funct3 / misalignment check for a request
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    // Unsigned variants only exist for loads, so they are illegal on stores.
    function automatic logic req_err(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] byte_off);
        logic bad_f3;
        logic misaligned;
        bad_f3     = 1'b0;
        misaligned = 1'b0;
        case (funct3)
            F3_B:  ;
            F3_H:  misaligned = byte_off[0];
            F3_W:  misaligned = (byte_off != 2'b00);
            F3_BU: bad_f3 = we;
            F3_HU: begin
                bad_f3     = we;
                misaligned = byte_off[0];
            end
            default: bad_f3 = 1'b1;
        endcase
        return bad_f3 | misaligned;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering.
//   funct3   - access size/sign encoding
//   byte_off - addr[1:0] of the access
//   wdata    - right-aligned store data
//   old_word - current memory word at the access index
//   st_word  - old_word with the store lanes merged in
//   ld_data  - selected lane(s), sign/zero extended
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [31:0] st_word,
    output logic [31:0] ld_data
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    always_comb begin
        st_word = old_word;
        case (funct3)
            F3_B:    st_word[{byte_off, 3'b000} +: 8]        = wdata[7:0];
            F3_H:    st_word[{byte_off[1], 4'b0000} +: 16]   = wdata[15:0];
            F3_W:    st_word                                 = wdata;
            default: ;
        endcase
    end

    always_comb begin
        sel_b   = old_word[{byte_off, 3'b000} +: 8];
        sel_h   = old_word[{byte_off[1], 4'b0000} +: 16];
        ld_data = 32'h0;
        case (funct3)
            F3_B:    ld_data = {{24{sel_b[7]}}, sel_b};
            F3_H:    ld_data = {{16{sel_h[15]}}, sel_h};
            F3_W:    ld_data = old_word;
            F3_BU:   ld_data = {24'h0, sel_b};
            F3_HU:   ld_data = {16'h0, sel_h};
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with fixed latency.
//   clk_i, reset_i (sync, active-low)
//   req_valid_i/req_ready_o, req_we_i, req_funct3_i, req_addr_i, req_wdata_i
//   rsp_valid_o/rsp_ready_i, rsp_rdata_o, rsp_err_o
// A request accepted at edge T produces a response at edge T+LAT which is
// held until rsp_ready_i; the next accept can happen one edge after that.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int LAT   = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int AW = $clog2(DEPTH);

    state_t      state, state_nxt;
    logic [2:0]  cnt;
    dmem_req_t   req_q;
    logic [31:0] mem [DEPTH];

    logic [AW-1:0] idx;
    logic          accept;
    logic          fire;
    logic          err;
    logic [31:0]   st_word;
    logic [31:0]   ld_data;
    logic          unused_addr_hi;

    assign req_ready_o    = (state == IDLE) && reset_i;
    assign accept         = req_valid_i && req_ready_o;
    assign fire           = (state == BUSY) && (cnt == 3'd0);
    assign idx            = req_q.addr[AW+1:2];
    assign err            = req_err(req_q.we, req_q.funct3, req_q.addr[1:0]);
    assign unused_addr_hi = ^req_q.addr[31:AW+2];

    dmem_lane_align u_align (
        .funct3   (req_q.funct3),
        .byte_off (req_q.addr[1:0]),
        .wdata    (req_q.wdata),
        .old_word (mem[idx]),
        .st_word  (st_word),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)       state_nxt = BUSY;
            BUSY:    if (cnt == 3'd0)  state_nxt = RESP;
            RESP:    if (rsp_ready_i)  state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt         <= 3'd0;
            req_q       <= '0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= 32'h0;
        end else begin
            if (accept) begin
                req_q <= '{we: req_we_i, funct3: req_funct3_i,
                           addr: req_addr_i, wdata: req_wdata_i};
                cnt   <= 3'(LAT - 1);
            end
            if (state == BUSY && cnt != 3'd0) cnt <= cnt - 3'd1;
            if (fire) begin
                rsp_valid_o <= 1'b1;
                rsp_err_o   <= err;
                rsp_rdata_o <= (err || req_q.we) ? 32'h0 : ld_data;
            end
            if (state == RESP && rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
                rsp_err_o   <= 1'b0;
                rsp_rdata_o <= 32'h0;
            end
        end
    end

    // Array has no reset; the commit is gated by reset_i so a reset landing
    // on the commit edge still discards the store.
    always_ff @(posedge clk_i) begin
        if (reset_i && fire && req_q.we && !err) mem[idx] <= st_word;
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst2, rst3;
    logic        req_valid, we, rsp_ready;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic        rdy2, vld2, er2, rdy3, vld3, er3;
    logic [31:0] rd2, rd3;
    int          npass = 0;
    int          ntotal = 0;

    always #5 clk = ~clk;

    // Both instances share the request/response inputs; the one not under
    // test is held in reset, which keeps its req_ready_o low.
    dmem_responder #(.DEPTH(32), .LAT(2)) u2 (
        .clk_i(clk), .reset_i(rst2), .req_valid_i(req_valid), .req_ready_o(rdy2),
        .req_we_i(we), .req_funct3_i(f3), .req_addr_i(addr), .req_wdata_i(wdata),
        .rsp_valid_o(vld2), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd2), .rsp_err_o(er2));

    dmem_responder #(.DEPTH(32), .LAT(3)) u3 (
        .clk_i(clk), .reset_i(rst3), .req_valid_i(req_valid), .req_ready_o(rdy3),
        .req_we_i(we), .req_funct3_i(f3), .req_addr_i(addr), .req_wdata_i(wdata),
        .rsp_valid_o(vld3), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd3), .rsp_err_o(er3));

    function automatic logic o_rdy(int sel);        return sel != 0 ? rdy3 : rdy2; endfunction
    function automatic logic o_vld(int sel);        return sel != 0 ? vld3 : vld2; endfunction
    function automatic logic o_er(int sel);         return sel != 0 ? er3  : er2;  endfunction
    function automatic logic [31:0] o_rd(int sel);  return sel != 0 ? rd3  : rd2;  endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic xact(int sel, logic w, logic [2:0] f, logic [31:0] a, logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; we = w; f3 = f; addr = a; wdata = d;
        n = 0;
        while (!o_rdy(sel) && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!o_vld(sel) && lat < 20);
        rd = o_rd(sel);
        er = o_er(sel);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic run(string tag, int sel, logic w, logic [2:0] f, logic [31:0] a,
                       logic [31:0] d, logic [31:0] exp_rd, logic exp_er, int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(sel, w, f, a, d, rd, er, lat);
        chk({tag, ".rdata"}, rd, exp_rd);
        chk({tag, ".err"}, {31'b0, er}, {31'b0, exp_er});
        chk({tag, ".lat"}, lat, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst2 = 1'b0; rst3 = 1'b0; req_valid = 1'b0; we = 1'b0; f3 = 3'b0;
        addr = 32'h0; wdata = 32'h0; rsp_ready = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", {31'b0, rdy2}, 32'h0);
        chk("rst.valid", {31'b0, vld2}, 32'h0);
        chk("rst.err",   {31'b0, er2},  32'h0);
        chk("rst.rdata", rd2, 32'h0);
        chk("rst.ready3", {31'b0, rdy3}, 32'h0);
        rst2 = 1'b1;
        @(posedge clk);
        #1 chk("idle.ready", {31'b0, rdy2}, 32'h1);

        // word store/load, latency 2
        run("sw8",  0, 1'b1, F3_W, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        run("lw8",  0, 1'b0, F3_W, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 2);

        // byte store, signed/unsigned byte load
        run("sw8z", 0, 1'b1, F3_W,  32'h8, 32'h0, 32'h0, 1'b0, 2);
        run("sb9",  0, 1'b1, F3_B,  32'h9, 32'h80, 32'h0, 1'b0, 2);
        run("lb9",  0, 1'b0, F3_B,  32'h9, 32'h0, 32'hFFFFFF80, 1'b0, 2);
        run("lbu9", 0, 1'b0, F3_BU, 32'h9, 32'h0, 32'h00000080, 1'b0, 2);
        run("lw8b", 0, 1'b0, F3_W,  32'h8, 32'h0, 32'h00008000, 1'b0, 2);

        // errors leave memory alone and return zero data
        run("sw0",   0, 1'b1, F3_W,   32'h0, 32'h11223344, 32'h0, 1'b0, 2);
        run("sh3",   0, 1'b1, F3_H,   32'h3, 32'hFFFF, 32'h0, 1'b1, 2);
        run("lw0",   0, 1'b0, F3_W,   32'h0, 32'h0, 32'h11223344, 1'b0, 2);
        run("ld011", 0, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 2);

        // halfword lanes
        run("sh2",  0, 1'b1, F3_H,  32'h2, 32'h0000A5B6, 32'h0, 1'b0, 2);
        run("lh2",  0, 1'b0, F3_H,  32'h2, 32'h0, 32'hFFFFA5B6, 1'b0, 2);
        run("lhu2", 0, 1'b0, F3_HU, 32'h2, 32'h0, 32'h0000A5B6, 1'b0, 2);
        run("lh0",  0, 1'b0, F3_H,  32'h0, 32'h0, 32'h00003344, 1'b0, 2);
        run("lb3",  0, 1'b0, F3_B,  32'h3, 32'h0, 32'hFFFFFFA5, 1'b0, 2);
        run("lw2",  0, 1'b0, F3_W,  32'h2, 32'h0, 32'h0, 1'b1, 2);
        run("sbu0", 0, 1'b1, F3_BU, 32'h0, 32'h77, 32'h0, 1'b1, 2);
        run("lw0b", 0, 1'b0, F3_W,  32'h0, 32'h0, 32'hA5B63344, 1'b0, 2);

        // address wrap modulo DEPTH*4
        run("sw80", 0, 1'b1, F3_W, 32'h80, 32'hCAFEF00D, 32'h0, 1'b0, 2);
        run("lw00", 0, 1'b0, F3_W, 32'h00, 32'h0, 32'hCAFEF00D, 1'b0, 2);

        // response backpressure with a pending request
        @(negedge clk);
        req_valid = 1'b1; we = 1'b0; f3 = F3_W; addr = 32'h8; wdata = 32'h0;
        @(posedge clk);
        #1 we = 1'b1; addr = 32'h10; wdata = 32'h12345678;
        @(posedge clk);
        #1 chk("bp.t1.valid", {31'b0, vld2}, 32'h0);
        @(posedge clk);
        #1 chk("bp.t2.valid", {31'b0, vld2}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp.hold.valid", {31'b0, vld2}, 32'h1);
            chk("bp.hold.rdata", rd2, 32'h00008000);
            chk("bp.hold.ready", {31'b0, rdy2}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("bp.hs.valid", {31'b0, vld2}, 32'h0);
        chk("bp.hs.ready", {31'b0, rdy2}, 32'h1);
        @(posedge clk);
        #1 chk("bp.acc.ready", {31'b0, rdy2}, 32'h0);
        req_valid = 1'b0;
        @(posedge clk);
        #1 chk("bp.st.t1.valid", {31'b0, vld2}, 32'h0);
        @(posedge clk);
        #1;
        chk("bp.st.t2.valid", {31'b0, vld2}, 32'h1);
        chk("bp.st.err", {31'b0, er2}, 32'h0);
        chk("bp.st.rdata", rd2, 32'h0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        run("lw10", 0, 1'b0, F3_W, 32'h10, 32'h0, 32'h12345678, 1'b0, 2);

        // LAT=3 instance: reset while BUSY discards the store
        rst2 = 1'b0; rst3 = 1'b1;
        @(posedge clk);
        #1;
        run("u3.sw4", 1, 1'b1, F3_W, 32'h4, 32'h0BADF00D, 32'h0, 1'b0, 3);
        @(negedge clk);
        req_valid = 1'b1; we = 1'b1; f3 = F3_W; addr = 32'h4; wdata = 32'h99999999;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("u3.acc.valid", {31'b0, vld3}, 32'h0);
        @(negedge clk) rst3 = 1'b0;
        @(posedge clk);
        #1;
        chk("u3.rst.ready", {31'b0, rdy3}, 32'h0);
        chk("u3.rst.valid", {31'b0, vld3}, 32'h0);
        @(negedge clk) rst3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 chk("u3.noresp", {31'b0, vld3}, 32'h0);
        end
        run("u3.lw4", 1, 1'b0, F3_W, 32'h4, 32'h0, 32'h0BADF00D, 1'b0, 3);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, meaning the number of 32-bit memory words (power of two, 4..1024).
REQ-002 The block SHALL have parameter LAT, default 2, meaning the number of clock edges from request accept to response valid (1..7).
REQ-003 Port clk_i, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 Port reset_i, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port req_valid_i, input, 1 bit: the initiator presents a request.
REQ-006 Port req_ready_o, output, 1 bit: the responder can accept a request.
REQ-007 Port req_we_i, input, 1 bit: 1 = store, 0 = load.
REQ-008 Port req_funct3_i, input, 3 bits: RV32I load/store size and sign encoding.
REQ-009 Port req_addr_i, input, 32 bits: byte address.
REQ-010 Port req_wdata_i, input, 32 bits: store data, right-aligned.
REQ-011 Port rsp_valid_o, output, 1 bit: response present.
REQ-012 Port rsp_ready_i, input, 1 bit: the initiator accepts the response.
REQ-013 Port rsp_rdata_o, output, 32 bits: load data after extension; 0 for stores and errors.
REQ-014 Port rsp_err_o, output, 1 bit: the request was misaligned or had an illegal funct3.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-016 req_ready_o SHALL be 1 only in IDLE, and only one request SHALL be outstanding at any time.
REQ-017 A request SHALL be accepted on an edge where req_valid_i and req_ready_o are both 1.
REQ-018 On accept, the block SHALL capture we, funct3, addr and wdata, load a latency counter with LAT-1, and move to BUSY.
REQ-019 In BUSY, the counter SHALL decrement on each edge.
REQ-020 On the BUSY edge where the counter equals 0, the block SHALL commit the store or sample the load, register the response, and move to RESP.
REQ-021 rsp_valid_o SHALL rise exactly LAT edges after the accepting edge.
REQ-022 In RESP, rsp_valid_o, rsp_rdata_o and rsp_err_o SHALL hold stable until rsp_ready_i is 1.
REQ-023 On the RESP edge with rsp_ready_i=1, the block SHALL move to IDLE, so the earliest next accept is one edge later (no same-cycle turnaround).
REQ-024 A request arriving while not in IDLE SHALL be ignored; the initiator must hold req_valid_i until it is accepted.
REQ-025 The word index SHALL be addr[$clog2(DEPTH)+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH*4.
REQ-026 Legal loads SHALL be LB(000), LH(001), LW(010), LBU(100) and LHU(101); legal stores SHALL be SB(000), SH(001) and SW(010).
REQ-027 Any other funct3 SHALL set rsp_err_o=1.
REQ-028 A halfword access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL set rsp_err_o=1.
REQ-029 On error, the block SHALL not write memory and SHALL return rsp_rdata_o=0; the response timing SHALL be unchanged.
REQ-030 SB SHALL write byte lane addr[1:0]; SH SHALL write lanes {addr[1],1:0}; SW SHALL write all four lanes; other lanes SHALL be preserved.
REQ-031 LB/LH SHALL sign-extend the selected lane; LBU/LHU SHALL zero-extend it; LW SHALL return the full word.
REQ-032 A store response SHALL carry rsp_rdata_o=0 and rsp_err_o=0 when legal.

Reset
REQ-033 When reset_i=0 at an edge, the FSM SHALL go to IDLE, the counter SHALL clear, and rsp_valid_o, rsp_err_o and rsp_rdata_o SHALL be 0.
REQ-034 While reset_i=0, req_ready_o SHALL be 0.
REQ-035 Reset during BUSY SHALL discard the pending store, and memory SHALL be unmodified.
REQ-036 Reset during RESP SHALL drop the response.
REQ-037 The memory array SHALL not be cleared by reset.

Structure
REQ-038 Package dmem_pkg SHALL hold the state enum (IDLE, BUSY, RESP) and the funct3 constants F3_B, F3_H, F3_W, F3_BU and F3_HU.
REQ-039 The single sub-module dmem_lane_align SHALL be combinational and perform store lane merge plus load extract/extend; the top SHALL hold the FSM, counter and array.

Verification
REQ-040 LAT=2, SW 0xDEADBEEF @0x8 accepted at edge T: rsp_valid_o rises at T+2 with err=0; a following LW @0x8 returns 0xDEADBEEF.
REQ-041 SB 0x80 @0x9 over word 0x00000000, then LB @0x9 returns 0xFFFFFF80, LBU @0x9 returns 0x00000080, and LW @0x8 returns 0x00008000.
REQ-042 SH @0x3 returns err=1 and the word at 0x0 is unchanged; a load with funct3=011 returns err=1 and rdata=0.
REQ-043 Holding rsp_ready_i=0 for 5 cycles keeps the response stable and req_ready_o=0; a request presented during that time is accepted only after the RESP handshake plus 1 edge.
REQ-044 Asserting reset_i=0 one edge after accepting SW @0x4 (LAT=3): no response appears, and a later LW @0x4 returns the prior contents.
REQ-045 With DEPTH=32, SW to 0x80 then LW from 0x00 returns the same data (wrap).
